mem_arbiter: RTL and testbench

- Arbitrates one shared single-port memory between instruction fetch (IF port) and load/store data access (D port) in the pipelined MIPS core.
- Sequences each access through issue, fixed-latency wait and response phases, and returns a one-cycle ready pulse per transaction.
- Data port has priority over fetch; a streak limit prevents fetch starvation.
- The core's stall logic uses ready/busy to hold IF and MEM stages.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the mem_arbiter and its two requesters plus the memory.
// slave: arbiter side; master: core/memory side (MEM_ALIGN_CHECK_EN adds if_err/d_err).
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic          if_err;
    logic          d_err;
`endif

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
`ifdef MEM_ALIGN_CHECK_EN
        , output if_err, d_err
`endif
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
`ifdef MEM_ALIGN_CHECK_EN
        , input if_err, d_err
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter: fetch vs data, data priority with streak limit.
// Ports: clk, reset (async active-low), bus (mem_arbiter_if.slave); macro MEM_ALIGN_CHECK_EN.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(MAX_STREAK);
    localparam logic [3:0]    WAIT_LOAD  = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_own_d;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_d_rdata;
    logic [SW-1:0] r_streak;
    logic [3:0]    r_wcnt;
`ifdef MEM_ALIGN_CHECK_EN
    logic          r_err;
`endif

    logic          w_req_any;
    logic          w_grant;
    logic          w_grant_d;
    logic          w_skip;
    logic          w_issue;
    logic          w_done;
    logic [AW-1:0] w_sel_addr;

    // Data wins unless fetch has been passed over MAX_STREAK times in a row.
    always_comb begin
        w_req_any  = bus.if_req | bus.d_req;
        w_grant_d  = bus.d_req & ~(bus.if_req & (r_streak == STREAK_TOP));
        w_grant    = (r_state == S_IDLE) & w_req_any;
        w_sel_addr = w_grant_d ? bus.d_addr : bus.if_addr;
`ifdef MEM_ALIGN_CHECK_EN
        w_skip     = |w_sel_addr[1:0];
`else
        w_skip     = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req_any) w_next = w_skip ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_wcnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_own_d    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_streak   <= '0;
            r_wcnt     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            if (w_grant) begin
                r_own_d <= w_grant_d;
                r_we    <= w_grant_d & bus.d_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_grant_d ? bus.d_wdata : '0;
`ifdef MEM_ALIGN_CHECK_EN
                r_err   <= w_skip;
`endif
                // Only contested data grants count toward starving fetch.
                if (!w_grant_d) begin
                    r_streak <= '0;
                end else if (bus.if_req && r_streak != STREAK_TOP) begin
                    r_streak <= r_streak + 1'b1;
                end
            end
            if (r_state == S_ISSUE) begin
                r_wcnt <= WAIT_LOAD;
            end else if (r_state == S_WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
            // Capture on the last wait cycle; stores leave d_rdata alone.
            if (r_state == S_WAIT && r_wcnt == 4'd0 && !r_we) begin
                if (r_own_d) begin
                    r_d_rdata <= bus.mem_rdata;
                end else begin
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    always_comb begin
        w_issue       = (r_state == S_ISSUE);
        w_done        = (r_state == S_DONE);
        bus.mem_en    = w_issue;
        bus.mem_we    = w_issue & r_we;
        bus.mem_addr  = w_issue ? r_addr : '0;
        bus.mem_wdata = w_issue ? r_wdata : '0;
        bus.busy      = (r_state != S_IDLE);
        bus.if_ready  = w_done & ~r_own_d;
        bus.d_ready   = w_done & r_own_d;
        bus.if_rdata  = r_if_rdata;
        bus.d_rdata   = r_d_rdata;
`ifdef MEM_ALIGN_CHECK_EN
        bus.if_err    = w_done & ~r_own_d & r_err;
        bus.d_err     = w_done & r_own_d & r_err;
`endif
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level schedule model.
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int LAT = 2;
    localparam int MS  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(.AW(AW), .MEM_LAT(LAT), .MAX_STREAK(MS)) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;

    // Memory: writes at issue, read data valid LAT cycles after mem_en, junk otherwise.
    logic [31:0] mem [0:255];
    bit          en_h [0:16];
    logic [31:0] ad_h [0:16];
    always @(negedge clk) begin
        for (int i = 16; i > 0; i--) begin
            en_h[i] = en_h[i-1];
            ad_h[i] = ad_h[i-1];
        end
        en_h[0] = bus.mem_en;
        ad_h[0] = bus.mem_addr;
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        bus.mem_rdata = en_h[LAT] ? mem[ad_h[LAT][9:2]] : $urandom;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`endif
        return a;
    endfunction

    task automatic new_if();
        bus.if_req  = 1'b1;
        bus.if_addr = rand_addr();
    endtask

    task automatic new_d();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = $urandom;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({bus.mem_en, bus.mem_we, bus.busy, bus.if_ready, bus.d_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=00000",
                     {bus.mem_en, bus.mem_we, bus.busy, bus.if_ready, bus.d_ready});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata});
        end
        total++;
        if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata got=%h exp=0", {bus.if_rdata, bus.d_rdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        mem[8'h10] = 32'hDEADBEEF;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h40;
        @(negedge clk);
        total++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h40}) begin
            bad++;
            $display("FAIL fetch_issue got=%b/%b/%h exp=1/0/40",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        repeat (2) @(negedge clk);
        total++;
        if (bus.if_ready !== 1'b0) begin
            bad++;
            $display("FAIL fetch_early_ready got=%b exp=0", bus.if_ready);
        end
        @(negedge clk);
        total++;
        if ({bus.if_ready, bus.d_ready, bus.if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL fetch_done got=%b/%b/%h exp=1/0/deadbeef",
                     bus.if_ready, bus.d_ready, bus.if_rdata);
        end
        exp_i = 32'hDEADBEEF;
        bus.if_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.if_ready} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_idle got=%b exp=00", {bus.busy, bus.if_ready});
        end
    endtask

    task automatic test_store();
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h100;
        bus.d_wdata = 32'h12345678;
        @(negedge clk);
        total++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {2'b11, 32'h100, 32'h12345678}) begin
            bad++;
            $display("FAIL store_issue got=%b/%b/%h/%h exp=1/1/100/12345678",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        total++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'h0) begin
            bad++;
            $display("FAIL store_hold got=%b/%h/%h exp=0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({bus.d_ready, bus.if_ready, bus.d_rdata} !== {2'b10, exp_d}) begin
            bad++;
            $display("FAIL store_done got=%b/%b/%h exp=1/0/%h",
                     bus.d_ready, bus.if_ready, bus.d_rdata, exp_d);
        end
        total++;
        if (mem[8'h40] !== 32'h12345678) begin
            bad++;
            $display("FAIL store_mem got=%h exp=12345678", mem[8'h40]);
        end
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit got [0:9];
        bit expv [0:9];
        int s = 0;
        int k = 0;
        int c = 0;
        for (int j = 0; j < 10; j++) begin
            expv[j] = (s != MS);
            if (expv[j]) s++;
            else s = 0;
        end
        bus.if_req = 1'b1;
        bus.if_addr = 32'h200;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h300;
        while (k < 10 && c < 200) begin
            @(negedge clk);
            c++;
            if (bus.d_ready) begin
                got[k] = 1'b1;
                k++;
                bus.d_addr = bus.d_addr + 4;
            end else if (bus.if_ready) begin
                got[k] = 1'b0;
                k++;
                bus.if_addr = bus.if_addr + 4;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        total++;
        if (k != 10) begin
            bad++;
            $display("FAIL contention_count got=%0d exp=10", k);
        end
        for (int j = 0; j < k; j++) begin
            total++;
            if (got[j] !== expv[j]) begin
                bad++;
                $display("FAIL contention_order idx=%0d got_d=%b exp_d=%b",
                         j, got[j], expv[j]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c = 0;
        bit seen = 0;
        logic [31:0] v;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h80;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.mem_en, bus.busy, bus.if_ready, bus.d_ready} !== 4'b0) begin
            bad++;
            $display("FAIL rstmid_ctl got=%b exp=0000",
                     {bus.mem_en, bus.busy, bus.if_ready, bus.d_ready});
        end
        bus.if_req = 1'b0;
        exp_i = '0;
        exp_d = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total++;
            if ({bus.if_ready, bus.busy, bus.if_rdata} !== 34'h0) begin
                bad++;
                $display("FAIL rstmid_hold got=%b/%b/%h exp=0/0/0",
                         bus.if_ready, bus.busy, bus.if_rdata);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        v = $urandom;
        mem[8'h21] = v;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h84;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (bus.if_ready) seen = 1;
        end
        bus.if_req = 1'b0;
        total++;
        if (!seen || c != LAT + 2) begin
            bad++;
            $display("FAIL rstmid_latency got=%0d seen=%b exp=%0d", c, seen, LAT + 2);
        end
        total++;
        if (bus.if_rdata !== v) begin
            bad++;
            $display("FAIL rstmid_rdata got=%h exp=%h", bus.if_rdata, v);
        end
        exp_i = v;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t [0:1];
        logic [31:0] rd [0:1];
        logic [31:0] a;
        logic [31:0] b;
        int nr = 0;
        int c = 0;
        a = $urandom;
        b = $urandom;
        mem[0] = a;
        mem[1] = b;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h0;
        while (nr < 2 && c < 40) begin
            @(negedge clk);
            c++;
            if (bus.d_ready) begin
                t[nr] = c;
                rd[nr] = bus.d_rdata;
                nr++;
                if (nr == 1) bus.d_addr = 32'h4;
                else bus.d_req = 1'b0;
            end
        end
        bus.d_req = 1'b0;
        total++;
        if (nr != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=2", nr);
        end else begin
            total++;
            if (t[0] != LAT + 2 || t[1] - t[0] != LAT + 3) begin
                bad++;
                $display("FAIL b2b_timing got=%0d,%0d exp=%0d,%0d",
                         t[0], t[1] - t[0], LAT + 2, LAT + 3);
            end
            total++;
            if (rd[0] !== a || rd[1] !== b) begin
                bad++;
                $display("FAIL b2b_rdata got=%h,%h exp=%h,%h", rd[0], rd[1], a, b);
            end
            exp_d = b;
        end
        @(negedge clk);
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h102;
        @(negedge clk);
        total++;
        if ({bus.mem_en, bus.d_ready, bus.d_err, bus.if_err, bus.d_rdata} !==
            {4'b0110, exp_d}) begin
            bad++;
            $display("FAIL align_err got=%b/%b/%b/%b/%h exp=0/1/1/0/%h",
                     bus.mem_en, bus.d_ready, bus.d_err, bus.if_err, bus.d_rdata, exp_d);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.d_ready, bus.d_err} !== 3'b000) begin
            bad++;
            $display("FAIL align_idle got=%b exp=000", {bus.busy, bus.d_ready, bus.d_err});
        end
    endtask
`endif

    task automatic test_random();
        int g = -100;
        int free = 0;
        int streak = 0;
        int dur;
        bit g_d = 0;
        bit g_we = 0;
        bit g_mis = 0;
        logic [AW-1:0] g_addr = '0;
        logic [31:0] g_wd = '0;
        logic [31:0] g_dat = '0;
        bit e_en;
        bit e_busy;
        bit e_rdy;
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_i = '0;
        exp_d = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            dur = g_mis ? 1 : LAT + 2;
            e_en = (n == g + 1) && !g_mis;
            e_busy = (n > g) && (n <= g + dur);
            e_rdy = (n == g + dur);
            if (e_rdy && !g_mis && !(g_d && g_we)) begin
                if (g_d) exp_d = g_dat;
                else exp_i = g_dat;
            end
            total++;
            if ({bus.mem_en, bus.busy, bus.if_ready, bus.d_ready} !==
                {e_en, e_busy, e_rdy & ~g_d, e_rdy & g_d}) begin
                bad++;
                $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", n,
                         {bus.mem_en, bus.busy, bus.if_ready, bus.d_ready},
                         {e_en, e_busy, e_rdy & ~g_d, e_rdy & g_d});
            end
            total++;
            if (bus.if_rdata !== exp_i || bus.d_rdata !== exp_d) begin
                bad++;
                $display("FAIL rnd_rdata cyc=%0d got=%h,%h exp=%h,%h", n,
                         bus.if_rdata, bus.d_rdata, exp_i, exp_d);
            end
            total++;
            if (e_en) begin
                if (bus.mem_addr !== g_addr || bus.mem_we !== g_we ||
                    (g_we && bus.mem_wdata !== g_wd)) begin
                    bad++;
                    $display("FAIL rnd_issue cyc=%0d got=%h/%b/%h exp=%h/%b/%h", n,
                             bus.mem_addr, bus.mem_we, bus.mem_wdata, g_addr, g_we, g_wd);
                end
            end else if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'h0) begin
                bad++;
                $display("FAIL rnd_idle_bus cyc=%0d got=%b/%h/%h exp=0", n,
                         bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
`ifdef MEM_ALIGN_CHECK_EN
            total++;
            if ({bus.if_err, bus.d_err} !==
                {e_rdy & g_mis & ~g_d, e_rdy & g_mis & g_d}) begin
                bad++;
                $display("FAIL rnd_err cyc=%0d got=%b exp=%b", n, {bus.if_err, bus.d_err},
                         {e_rdy & g_mis & ~g_d, e_rdy & g_mis & g_d});
            end
`endif
            // Requesters: retire on ready, scramble after grant, raise at random.
            if (e_rdy && !g_d) begin
                if ($urandom_range(0, 1) == 1) new_if();
                else bus.if_req = 1'b0;
            end else if (!bus.if_req) begin
                if ($urandom_range(0, 2) == 0) new_if();
            end else if (!g_d && n > g && n < g + dur) begin
                bus.if_addr = rand_addr();
            end
            if (e_rdy && g_d) begin
                if ($urandom_range(0, 1) == 1) new_d();
                else bus.d_req = 1'b0;
            end else if (!bus.d_req) begin
                if ($urandom_range(0, 2) == 0) new_d();
            end else if (g_d && n > g && n < g + dur) begin
                bus.d_addr = rand_addr();
                bus.d_wdata = $urandom;
                bus.d_we = 1'($urandom_range(0, 1));
            end
            // Arbitration at the free slot, from the rules.
            if (n >= free && (bus.if_req || bus.d_req)) begin
                g_d = bus.d_req && !(bus.if_req && streak == MS);
                if (!g_d) streak = 0;
                else if (bus.if_req && streak < MS) streak++;
                g = n;
                g_addr = g_d ? bus.d_addr : bus.if_addr;
                g_we = g_d && bus.d_we;
                g_wd = bus.d_wdata;
`ifdef MEM_ALIGN_CHECK_EN
                g_mis = (g_addr[1:0] != 2'b00);
`else
                g_mis = 1'b0;
`endif
                g_dat = mem[g_addr[9:2]];
                free = n + (g_mis ? 2 : LAT + 3);
            end
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (LAT + 4) @(negedge clk);
    endtask

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
